// File: rtl/channel_failover_scheduler.sv
// channel_failover_scheduler: picks the active TS input from channel health, priority list and revert holdoff.
// Define SWITCH_COUNT_EN to build the saturating automatic-switch counter; otherwise switch_count is 0.
module channel_failover_scheduler #(
  parameter int WIN_CYCLES = 2700000,
  parameter int ERR_THRESH = 8,
  parameter int TICK_DIV = 27000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fallback_enable,
  input  logic        manual_enable,
  input  logic [1:0]  manual_channel,
  input  logic [7:0]  channel_priority,
  input  logic [19:0] reset_timer,
  input  logic [3:0]  signal_present,
  input  logic [7:0]  error_count_ch0,
  input  logic [7:0]  error_count_ch1,
  input  logic [7:0]  error_count_ch2,
  input  logic [7:0]  error_count_ch3,
  output logic [1:0]  active_channel,
  output logic [3:0]  channel_healthy,
  output logic        switch_pulse,
  output logic [2:0]  sched_state,
  output logic [15:0] switch_count
);
  localparam int WW = $clog2(WIN_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV + 1);
  typedef enum logic [2:0] {
    MANUAL = 3'd0, PRIMARY = 3'd1, FALLBACK = 3'd2, HOLDOFF = 3'd3, NO_SIGNAL = 3'd4, FIXED = 3'd5
  } state_t;
  state_t state, state_n;
  logic [WW-1:0] win_cnt;
  logic [TW-1:0] tick, tick_n;
  logic [19:0] holdoff, ho_n;
  logic [3:0][7:0] cnt, snap;
  logic [3:0] err_bad;
  logic [1:0] cand, act_n;
  logic [2:0] cand_pos, act_pos;
  logic cand_ok, higher, take, win_wrap;
  assign cnt = {error_count_ch3, error_count_ch2, error_count_ch1, error_count_ch0};
  assign win_wrap = win_cnt == WW'(WIN_CYCLES - 1);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_cnt <= '0;
      err_bad <= '0;
      snap <= '0;
      channel_healthy <= '0;
    end else begin
      win_cnt <= win_wrap ? '0 : win_cnt + 1'b1;
      channel_healthy <= signal_present & ~err_bad;
      if (win_wrap)
        for (int i = 0; i < 4; i++) begin
          err_bad[i] <= 32'(8'(cnt[i] - snap[i])) >= ERR_THRESH;
          snap[i] <= cnt[i];
        end
    end
  end
  // Scan from the lowest-priority entry so the earliest matching position wins.
  always_comb begin
    cand_ok = 1'b0;
    cand = '0;
    cand_pos = 3'd4;
    act_pos = 3'd4;
    for (int j = 3; j >= 0; j--) begin
      if (channel_healthy[channel_priority[2*j +: 2]]) begin
        cand_ok = 1'b1;
        cand = channel_priority[2*j +: 2];
        cand_pos = 3'(j);
      end
      if (channel_priority[2*j +: 2] == active_channel) act_pos = 3'(j);
    end
  end
  assign higher = cand_ok && cand_pos < act_pos;
  always_comb begin
    state_n = state;
    act_n = active_channel;
    ho_n = holdoff;
    tick_n = tick;
    take = 1'b0;
    if (manual_enable) begin
      state_n = MANUAL;
      act_n = manual_channel;
    end else if (!fallback_enable) begin
      state_n = FIXED;
      act_n = channel_priority[1:0];
    end else if (state == MANUAL || state == FIXED || state == NO_SIGNAL || !channel_healthy[active_channel]) begin
      take = 1'b1;
    end else if (state == FALLBACK) begin
      if (higher) begin
        state_n = HOLDOFF;
        ho_n = reset_timer;
        tick_n = '0;
      end
    end else if (state == HOLDOFF) begin
      if (!higher) begin
        state_n = FALLBACK;
        ho_n = '0;
      end else if (holdoff == '0) begin
        take = 1'b1;
      end else if (tick == TW'(TICK_DIV - 1)) begin
        tick_n = '0;
        ho_n = holdoff - 1'b1;
      end else begin
        tick_n = tick + 1'b1;
      end
    end
    if (take) begin
      state_n = !cand_ok ? NO_SIGNAL : cand_pos == 3'd0 ? PRIMARY : FALLBACK;
      act_n = cand_ok ? cand : active_channel;
      ho_n = '0;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= PRIMARY;
      active_channel <= '0;
      switch_pulse <= 1'b0;
      holdoff <= '0;
      tick <= '0;
    end else begin
      state <= state_n;
      active_channel <= act_n;
      switch_pulse <= act_n != active_channel;
      holdoff <= ho_n;
      tick <= tick_n;
    end
  end
  assign sched_state = state;
`ifdef SWITCH_COUNT_EN
  logic [15:0] sw_cnt;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sw_cnt <= '0;
    else if (take && act_n != active_channel && sw_cnt != 16'hFFFF) sw_cnt <= sw_cnt + 1'b1;
  end
  assign switch_count = sw_cnt;
`else
  assign switch_count = '0;
`endif
endmodule
